// File: rtl/y86_bus_responder.sv
// y86 memory-side bus responder: byte RAM with same-cycle reads, valid/ready TX byte port
// and sticky overflow. Define Y86_BUS_WBUF_EN for the posted write buffer with forwarding.
module y86_bus_responder #(
    parameter int unsigned MEM_BYTES  = 4096,
    parameter int unsigned WBUF_DEPTH = 4,
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  bus_A,
    input  logic [31:0]                  bus_out,
    input  logic                         bus_RE,
    input  logic                         bus_WE,
    output logic [31:0]                  bus_in,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [$clog2(WBUF_DEPTH):0]  wbuf_level,
    output logic                         err_ovf,
    output logic [15:0]                  rd_count,
    output logic [15:0]                  wr_count
);
    localparam int unsigned AW = $clog2(MEM_BYTES);

    logic [7:0]    mem [MEM_BYTES];
    logic          io_sel;
    logic [7:0]    io_off;
    logic [AW-1:0] base;
    logic          ram_wr;
    logic          tx_wr;
    logic          wb_ovf;
    logic [AW-1:0] byte_addr [4];
    logic [31:0]   ram_word;

    assign io_sel = (bus_A[31:8] == IO_BASE[31:8]);
    assign io_off = bus_A[7:0] - IO_BASE[7:0];
    assign base   = bus_A[AW-1:0];
    assign ram_wr = bus_WE & ~io_sel;
    assign tx_wr  = bus_WE & io_sel & (io_off == 8'd0);

    // Each byte lane wraps around the RAM independently
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr[k] = base + AW'(k);
        end
    end

`ifdef Y86_BUS_WBUF_EN
    localparam int unsigned PW = $clog2(WBUF_DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [AW-1:0] wb_addr [WBUF_DEPTH];
    logic [31:0]   wb_data [WBUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          pop;
    logic          push;

    // A full buffer still accepts a write when the same edge drains an entry
    assign full   = (level == LW'(WBUF_DEPTH));
    assign pop    = ~bus_RE & (level != '0);
    assign push   = ram_wr & (~full | pop);
    assign wb_ovf = ram_wr & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wb_addr[wr_ptr] <= base;
            wb_data[wr_ptr] <= bus_out;
        end
    end

    // Drain the oldest entry into RAM
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int j = 0; j < 4; j++) begin
                mem[wb_addr[rd_ptr] + AW'(j)] <= wb_data[rd_ptr][8*j +: 8];
            end
        end
    end

    assign wbuf_level = level;
`else
    assign wb_ovf = 1'b0;

    always_ff @(posedge clk) begin
        if (ram_wr && !rst) begin
            for (int j = 0; j < 4; j++) begin
                mem[byte_addr[j]] <= bus_out[8*j +: 8];
            end
        end
    end

    assign wbuf_level = '0;
`endif

    // RAM word assembly; walking oldest to newest lets the newest covering entry win
    always_comb begin
        ram_word = '0;
        for (int k = 0; k < 4; k++) begin
            ram_word[8*k +: 8] = mem[byte_addr[k]];
`ifdef Y86_BUS_WBUF_EN
            for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
                if (LW'(i) < level) begin
                    for (int j = 0; j < 4; j++) begin
                        if ((wb_addr[rd_ptr + PW'(i)] + AW'(j)) == byte_addr[k]) begin
                            ram_word[8*k +: 8] = wb_data[rd_ptr + PW'(i)][8*j +: 8];
                        end
                    end
                end
            end
`endif
        end
    end

    always_comb begin
        bus_in = '0;
        if (bus_RE) begin
            if (io_sel) begin
                case (io_off)
                    8'd0:    bus_in = {24'd0, tx_data};
                    8'd4:    bus_in = {30'd0, tx_valid, err_ovf};
                    default: bus_in = '0;
                endcase
            end else begin
                bus_in = ram_word;
            end
        end
    end

    // TX holding register, sticky overflow and access counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            err_ovf  <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (bus_RE) rd_count <= rd_count + 16'd1;
            if (bus_WE) wr_count <= wr_count + 16'd1;
            if (tx_valid) begin
                if (tx_ready) tx_valid <= 1'b0;
            end else if (tx_wr) begin
                tx_valid <= 1'b1;
                tx_data  <= bus_out[7:0];
            end
            if ((tx_wr & tx_valid) | wb_ovf) err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_y86_bus_responder.sv
// Randomized self-checking bench for y86_bus_responder against a queue/array reference model.
`timescale 1ns/1ps
module tb_y86_bus_responder;
    localparam int unsigned MEM_BYTES  = 4096;
    localparam int unsigned WBUF_DEPTH = 4;
    localparam logic [31:0] IO_BASE    = 32'hFFFF_FF00;
`ifdef Y86_BUS_WBUF_EN
    localparam bit WBUF = 1'b1;
`else
    localparam bit WBUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_A, bus_out, bus_in;
    logic        bus_RE, bus_WE;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic [2:0]  wbuf_level;
    logic        err_ovf;
    logic [15:0] rd_count, wr_count;

    y86_bus_responder #(.MEM_BYTES(MEM_BYTES), .WBUF_DEPTH(WBUF_DEPTH), .IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .bus_A(bus_A), .bus_out(bus_out), .bus_RE(bus_RE),
        .bus_WE(bus_WE), .bus_in(bus_in), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .wbuf_level(wbuf_level), .err_ovf(err_ovf),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference: lmem is what the core sees, pmem is the physical RAM, q* are posted writes
    logic [7:0]  lmem [MEM_BYTES];
    logic [7:0]  pmem [MEM_BYTES];
    logic [31:0] qa[$];
    logic [31:0] qd[$];
    logic        m_txv, m_ovf;
    logic [7:0]  m_txd;
    logic [15:0] m_rd, m_wr;
    logic [31:0] rv, old200;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic void lwrite(input logic [31:0] a, input logic [31:0] d);
        for (int j = 0; j < 4; j++) lmem[(a + 32'(j)) % MEM_BYTES] = d[8*j +: 8];
    endfunction

    function automatic void pwrite(input logic [31:0] a, input logic [31:0] d);
        for (int j = 0; j < 4; j++) pmem[(a + 32'(j)) % MEM_BYTES] = d[8*j +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic re, input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        if (!re) return '0;
        if (a[31:8] == IO_BASE[31:8]) begin
            if (a[7:0] == 8'h04) return {30'd0, m_txv, m_ovf};
            if (a[7:0] == 8'h00) return {24'd0, m_txd};
            return '0;
        end
        for (int k = 0; k < 4; k++) w[8*k +: 8] = lmem[(a + 32'(k)) % MEM_BYTES];
        return w;
    endfunction

    function automatic void model_edge(input logic re, input logic we, input logic [31:0] a,
                                       input logic [31:0] d, input logic rdy);
        logic io, txw, pop, acc;
        io  = (a[31:8] == IO_BASE[31:8]);
        txw = we && io && (a[7:0] == 8'h00);
        if (re) m_rd = m_rd + 16'd1;
        if (we) m_wr = m_wr + 16'd1;
        if (m_txv) begin
            if (txw) m_ovf = 1'b1;
            if (rdy) m_txv = 1'b0;
        end else if (txw) begin
            m_txv = 1'b1;
            m_txd = d[7:0];
        end
        if (WBUF) begin
            pop = !re && (qa.size() > 0);
            acc = we && !io && ((qa.size() < WBUF_DEPTH) || pop);
            if (we && !io && !acc) m_ovf = 1'b1;
            if (pop) begin
                pwrite(qa[0], qd[0]);
                void'(qa.pop_front());
                void'(qd.pop_front());
            end
            if (acc) begin
                qa.push_back(a);
                qd.push_back(d);
                lwrite(a, d);
            end
        end else if (we && !io) begin
            lwrite(a, d);
            pwrite(a, d);
        end
    endfunction

    function automatic void model_reset();
        qa.delete();
        qd.delete();
        for (int i = 0; i < int'(MEM_BYTES); i++) lmem[i] = pmem[i];
        m_txv = 1'b0; m_txd = '0; m_ovf = 1'b0; m_rd = '0; m_wr = '0;
    endfunction

    task automatic check_regs();
        check_eq("wbuf_level", 32'(wbuf_level), qa.size());
        check_eq("tx_valid", 32'(tx_valid), 32'(m_txv));
        check_eq("tx_data", 32'(tx_data), 32'(m_txd));
        check_eq("err_ovf", 32'(err_ovf), 32'(m_ovf));
        check_eq("rd_count", 32'(rd_count), 32'(m_rd));
        check_eq("wr_count", 32'(wr_count), 32'(m_wr));
    endtask

    // One bus cycle: entered and left 1ns after a rising edge
    task automatic cycle(input logic re, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy, output logic [31:0] rd_val);
        bus_RE = re; bus_WE = we; bus_A = a; bus_out = d; tx_ready = rdy;
        #3;
        rd_val = bus_in;
        check_eq($sformatf("bus_in@%08h", a), bus_in, model_read(re, a));
        @(posedge clk);
        model_edge(re, we, a, d, rdy);
        #1;
        check_regs();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_regs();
        bus_RE = 1'b0; bus_WE = 1'b0; tx_ready = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        re, we, rdy;
        logic [31:0] a;
        int          sel;
        rst = 1'b1; bus_A = '0; bus_out = '0; bus_RE = 1'b0; bus_WE = 1'b0; tx_ready = 1'b0;
        m_txv = 1'b0; m_txd = '0; m_ovf = 1'b0; m_rd = '0; m_wr = '0;
        #1;
        model_reset();
        check_regs();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fill every RAM byte through the bus, word 0 = 8B,45,04,90
        for (int i = 0; i < int'(MEM_BYTES / 4); i++)
            cycle(1'b0, 1'b1, 32'(4 * i), (i == 0) ? 32'h9004458B : $urandom, 1'b0, rv);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, rv);
        m_rd = '0; m_wr = '0;
        async_reset();

        cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, rv);
        check_eq("read0", rv, 32'h9004458B);
        check_eq("read0_rdcount", 32'(rd_count), 32'd1);

        cycle(1'b1, 1'b0, 32'd4094, 32'd0, 1'b0, rv);
        check_eq("wrap_hi", 32'(rv[31:16]), 32'h458B);

        cycle(1'b1, 1'b1, 32'd16, 32'hDEADBEEF, 1'b0, rv);
        cycle(1'b1, 1'b0, 32'd18, 32'd0, 1'b0, rv);
        check_eq("fwd_lo", 32'(rv[15:0]), 32'hDEAD);
        check_eq("fwd_level", 32'(wbuf_level), WBUF ? 32'd1 : 32'd0);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, rv);
        check_eq("drain_level", 32'(wbuf_level), 32'd0);
        cycle(1'b1, 1'b0, 32'd16, 32'd0, 1'b0, rv);
        check_eq("drained_word", rv, 32'hDEADBEEF);

        cycle(1'b0, 1'b1, IO_BASE, 32'h41, 1'b0, rv);
        check_eq("tx_set", 32'(tx_valid), 32'd1);
        cycle(1'b0, 1'b1, IO_BASE, 32'h42, 1'b0, rv);
        check_eq("tx_hold", 32'(tx_data), 32'h41);
        check_eq("tx_ovf", 32'(err_ovf), 32'd1);
        cycle(1'b1, 1'b0, IO_BASE + 32'd4, 32'd0, 1'b0, rv);
        check_eq("status", rv, 32'd3);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rv);
        check_eq("tx_done", 32'(tx_valid), 32'd0);

        old200 = model_read(1'b1, 32'd200);
        cycle(1'b1, 1'b1, 32'd100, 32'h1111_1111, 1'b0, rv);
        cycle(1'b1, 1'b1, 32'd200, 32'h2222_2222, 1'b0, rv);
        cycle(1'b1, 1'b1, 32'd300, 32'h3333_3333, 1'b0, rv);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, rv);
        async_reset();
        cycle(1'b1, 1'b0, 32'd100, 32'd0, 1'b0, rv);
        check_eq("rst_drained", rv, 32'h1111_1111);
        cycle(1'b1, 1'b0, 32'd200, 32'd0, 1'b0, rv);
        check_eq("rst_discard", rv, WBUF ? old200 : 32'h2222_2222);
        cycle(1'b1, 1'b0, 32'd300, 32'd0, 1'b0, rv);

        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 32'(32 + 4 * i), $urandom, 1'b0, rv);
        check_eq("ovf_level", 32'(wbuf_level), WBUF ? 32'd4 : 32'd0);
        check_eq("ovf_flag", 32'(err_ovf), WBUF ? 32'd1 : 32'd0);
        check_eq("ovf_wrcount", 32'(wr_count), 32'd5);

        // Random traffic with read-heavy phases to keep the buffer near full
        for (int n = 0; n < 3000; n++) begin
            re  = ((n / 16) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
            we  = ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 4)       a = 32'($urandom_range(0, 63));
            else if (sel < 6)  a = 32'($urandom_range(4088, 4095));
            else if (sel == 6) a = 32'h1000 * 32'($urandom_range(1, 1000)) + 32'($urandom_range(0, 63));
            else if (sel == 7) a = $urandom & 32'h7FFF_FFFF;
            else               a = IO_BASE + 32'(4 * $urandom_range(0, 2));
            cycle(re, we, a, $urandom, rdy, rv);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
